// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Streams sequential word fetches from instruction memory (one-cycle read
// latency) to the decoder through an output register backed by a one-entry
// skid buffer. Supports redirects (branch/jump), a terminal halt state and a
// sticky misaligned-redirect flag.
//
// Handshake: an instruction transfers to the decoder on every rising edge
// where ins_valid=1 and ins_ready=1; while ins_valid=1 and ins_ready=0 the
// ins/pc pair is held stable. imem_re=1 means imem_addr is issued at this
// edge and imem_rdata carries the word in the following cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_re,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        infl_q, infl_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_ins_q, out_ins_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_ins_q, skid_ins_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        misalign_q, misalign_d;

  logic run;
  logic hs;
  logic issue;

  // Issue decision: never fetch while a returning word could find both the
  // output register and the skid buffer occupied.
  always_comb begin
    run   = (state_q == RUN);
    hs    = out_valid_q & ins_ready;
    issue = rst_n & run & ~redirect & ~halt & ~skid_valid_q
            & ~(infl_q & out_valid_q & ~ins_ready);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM next state: HALTED is terminal until reset.
  always_comb begin
    state_d = state_q;
    if (run && halt) state_d = HALTED;
  end

  // Datapath next state: flush on halt/redirect, otherwise move words
  // memory -> output/skid and skid -> output.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    infl_d       = infl_q;
    infl_pc_d    = infl_pc_q;
    out_valid_d  = out_valid_q;
    out_ins_d    = out_ins_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_ins_d   = skid_ins_q;
    skid_pc_d    = skid_pc_q;
    misalign_d   = misalign_q;
    if (run) begin
      if (halt) begin
        // Halt wins over a simultaneous redirect: fetch_pc and the error
        // flag are left untouched.
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
        infl_d       = 1'b0;
      end else if (redirect) begin
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
        infl_d       = 1'b0;
        fetch_pc_d   = {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
      end else begin
        // Skid full implies nothing is in flight (issue is blocked while a
        // word lands in the skid), so these cases are exclusive.
        if (hs && skid_valid_q) begin
          out_ins_d    = skid_ins_q;
          out_pc_d     = skid_pc_q;
          skid_valid_d = 1'b0;
        end else if (infl_q && (!out_valid_q || hs)) begin
          out_valid_d = 1'b1;
          out_ins_d   = imem_rdata;
          out_pc_d    = infl_pc_q;
        end else if (infl_q) begin
          skid_valid_d = 1'b1;
          skid_ins_d   = imem_rdata;
          skid_pc_d    = infl_pc_q;
        end else if (hs) begin
          out_valid_d = 1'b0;
        end
        infl_d = issue;
        if (issue) begin
          infl_pc_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      infl_q       <= 1'b0;
      infl_pc_q    <= 32'd0;
      out_valid_q  <= 1'b0;
      out_ins_q    <= 32'd0;
      out_pc_q     <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_ins_q   <= 32'd0;
      skid_pc_q    <= 32'd0;
      misalign_q   <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      infl_q       <= infl_d;
      infl_pc_q    <= infl_pc_d;
      out_valid_q  <= out_valid_d;
      out_ins_q    <= out_ins_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_ins_q   <= skid_ins_d;
      skid_pc_q    <= skid_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  // Output mapping.
  always_comb begin
    imem_re      = issue;
    imem_addr    = fetch_pc_q;
    ins          = out_ins_q;
    pc           = out_pc_q;
    ins_valid    = out_valid_q;
    halted       = (state_q == HALTED);
    misalign_err = misalign_q;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Ports, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_re  out  1  instruction memory read strobe
- imem_addr  out  32  word-aligned fetch address
- imem_rdata  in  32  read data, valid exactly one cycle after imem_re
- ins  out  32  instruction to decoder
- pc  out  32  address of ins
- ins_valid  out  1  ins/pc valid
- ins_ready  in  1  decoder accepts ins this cycle
- redirect  in  1  branch/jump taken, single-cycle pulse
- redirect_pc  in  32  redirect target
- halt  in  1  decoder reports is_halt on the accepted instruction
- halted  out  1  fetch stopped
- misalign_err  out  1  sticky: redirect_pc[1:0] != 0 seen
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low (rst_n).

Function
REQ-004 State machine SHALL have states RUN and HALTED; reset enters RUN; RUN->HALTED when halt=1; HALTED exits only via reset.
REQ-005 Internal storage SHALL be: fetch_pc, in-flight flag plus its PC, output register (ins/pc/ins_valid), one-entry skid buffer.
REQ-006 imem_re SHALL be 1 iff state=RUN, redirect=0, halt=0, skid empty, and NOT (in-flight and ins_valid and !ins_ready).
REQ-007 imem_addr SHALL equal fetch_pc; on issue, fetch_pc <= fetch_pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and in-flight set with its PC.
REQ-008 Returning imem_rdata SHALL load the output register if it is empty or being consumed (ins_valid & ins_ready), else load the skid buffer.
REQ-009 On handshake (ins_valid & ins_ready) with skid full, the skid entry SHALL move to the output register in that edge.
REQ-010 While ins_valid=1 and ins_ready=0, ins and pc SHALL stay stable.
REQ-011 Throughput SHALL be one instruction per cycle with ins_ready held 1; latency imem_re -> ins_valid is 2 cycles.
REQ-012 Program order SHALL be preserved; no instruction dropped or duplicated except by flush.
REQ-013 redirect=1 SHALL: clear ins_valid and skid at the edge, discard any in-flight response, set fetch_pc <= {redirect_pc[31:2],2'b00}; first new imem_re the following cycle.
REQ-014 redirect with redirect_pc[1:0] != 0 SHALL set misalign_err (sticky until reset).
REQ-015 A handshake in the same cycle as redirect SHALL count as accepted.
REQ-016 halt=1 SHALL: stop issuing from that cycle, clear ins_valid and skid, discard in-flight response, set halted=1 next edge.
REQ-017 halt and redirect in the same cycle: halt SHALL win; fetch_pc unchanged, misalign_err not set.
REQ-018 In HALTED, imem_re=0, ins_valid=0, all inputs ignored.

Reset
REQ-019 While rst_n=0 (immediately, asynchronously): imem_re=0, ins_valid=0, ins=0, pc=0, halted=0, misalign_err=0, skid empty, in-flight clear, fetch_pc=RESET_PC, state RUN.
REQ-020 Reset mid-operation SHALL discard all in-flight and buffered instructions; first cycle after release issues imem_addr=RESET_PC.

Verification
REQ-021 Reset release, ins_ready=1, memory word at addr = addr: imem_re cycles 0,1,2...; ins_valid from cycle 2 with pc/ins 0,4,8... one per cycle.
REQ-022 Stall: ins_ready=0 cycles 5-8 -> at most two instructions captured (output+skid), imem_re low while full, ins/pc stable; on release, sequence resumes, no gaps/duplicates.
REQ-023 redirect=1 with redirect_pc=32'h100 while skid full -> ins_valid=0 next cycle, imem_addr=32'h100 next cycle, ins_valid with pc=32'h100 two cycles later; stale words never presented.
REQ-024 redirect_pc=32'h102 -> fetch from 32'h100, misalign_err=1 and held until reset.
REQ-025 halt and redirect (32'h200) same cycle -> halted=1 next cycle, imem_re=0 thereafter, no fetch of 32'h200; rst_n pulse mid-run -> outputs cleared immediately, restart at RESET_PC.
REQ-026 fetch_pc=32'hFFFF_FFFC issue -> next imem_addr 32'h0000_0000.
